// File: rtl/shared_divider_scheduler_pkg.sv
// Shared definitions for the divider scheduler: state encoding, default sizes
// and the quotient returned on a divide by zero.
package divider_sched_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_N_REQ = 4;

   // Wide enough for any supported WIDTH; users slice the low bits.
   localparam logic [63:0] DBZ_QUOT = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIVIDE  = 2'd1,
      RESPOND = 2'd2
   } sched_state_t;

endpackage

// File: rtl/shared_divider_scheduler_serial_divider.sv
// Serial signed restoring divider: one setup cycle, WIDTH shift-subtract
// cycles, one sign-fix cycle, then a single-cycle done pulse with results.
module serial_divider
   import divider_sched_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH + 1);

   logic             r_busy;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dbz;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_fits;
   logic             w_iter;

   // Magnitudes are unsigned, so the most-negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_div};
   assign w_fits   = (w_rem_sh >= {1'b0, r_div});
   assign w_iter   = r_busy && (r_cnt != CW'(WIDTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
         end else if (w_iter) begin
            r_cnt <= r_cnt + CW'(1);
         end else if (r_busy) begin
            r_busy <= 1'b0;
            done   <= 1'b1;
         end
      end
   end

   // Setup, iteration and sign-fix stages share the datapath registers.
   always_ff @(posedge clk) begin
      if (start) begin
         r_quo   <= f_abs(dividend);
         r_rem   <= '0;
         r_div   <= f_abs(divisor);
         r_neg_r <= dividend[WIDTH-1];
         r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         r_dbz   <= (divisor == '0);
      end else if (w_iter) begin
         r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
         r_quo <= {r_quo[WIDTH-2:0], w_fits};
      end else if (r_busy) begin
         // With a zero divisor r_rem ends up holding |dividend|, so the
         // remainder fix below restores the original dividend.
         quotient  <= r_dbz ? DBZ_QUOT[WIDTH-1:0] : f_neg_if(r_quo, r_neg_q);
         remainder <= f_neg_if(r_rem, r_neg_r);
         dbz       <= r_dbz;
      end
   end

endmodule

// File: rtl/shared_divider_scheduler.sv
// Round-robin front end that shares one serial_divider between N_REQ
// requesters using stb/ack handshakes on both request and response sides.
module shared_divider_scheduler
   import divider_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ*WIDTH-1:0] req_dividend,
   input  logic [N_REQ*WIDTH-1:0] req_divisor,
   input  logic [N_REQ-1:0]       req_stb,
   output logic [N_REQ-1:0]       req_ack,
   output logic [WIDTH-1:0]       resp_quotient,
   output logic [WIDTH-1:0]       resp_remainder,
   output logic                   resp_dbz,
   output logic [N_REQ-1:0]       resp_stb,
   input  logic [N_REQ-1:0]       resp_ack
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   sched_state_t     r_state;
   logic [IW-1:0]    r_last;
   logic [IW-1:0]    r_id;
   logic [IW-1:0]    w_win;
   logic             w_found;
   logic             w_start;
   logic             w_done;
   logic             w_dbz;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;

   // Search starts just past the last grant so every requester gets a turn.
   always_comb begin
      logic [IW-1:0] v_idx;
      v_idx   = '0;
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         v_idx = IW'((int'(r_last) + k) % N_REQ);
         if (!w_found && req_stb[v_idx]) begin
            w_found = 1'b1;
            w_win   = v_idx;
         end
      end
   end

   assign w_start = (r_state == IDLE) && w_found;

   serial_divider #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (w_start),
      .dividend (req_dividend[int'(w_win)*WIDTH +: WIDTH]),
      .divisor  (req_divisor[int'(w_win)*WIDTH +: WIDTH]),
      .done     (w_done),
      .quotient (w_quo),
      .remainder(w_rem),
      .dbz      (w_dbz)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_last         <= IW'(N_REQ - 1);
         r_id           <= '0;
         req_ack        <= '0;
         resp_stb       <= '0;
         resp_quotient  <= '0;
         resp_remainder <= '0;
         resp_dbz       <= 1'b0;
      end else begin
         req_ack <= '0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  req_ack <= N_REQ'(1) << w_win;
                  r_id    <= w_win;
                  r_last  <= w_win;
                  r_state <= DIVIDE;
               end
            end
            DIVIDE: begin
               if (w_done) begin
                  resp_quotient  <= w_quo;
                  resp_remainder <= w_rem;
                  resp_dbz       <= w_dbz;
                  resp_stb       <= N_REQ'(1) << r_id;
                  r_state        <= RESPOND;
               end
            end
            RESPOND: begin
               if (resp_ack[r_id]) begin
                  resp_stb <= '0;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shared_divider_scheduler.sv
// Randomised bench for shared_divider_scheduler against a transaction-level
// model: round-robin pick over pending requesters and integer division.
module tb_shared_divider_scheduler;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] req_dividend;
   logic [N*W-1:0] req_divisor;
   logic [N-1:0]   req_stb;
   logic [N-1:0]   req_ack;
   logic [W-1:0]   resp_quotient;
   logic [W-1:0]   resp_remainder;
   logic           resp_dbz;
   logic [N-1:0]   resp_stb;
   logic [N-1:0]   resp_ack;

   logic signed [W-1:0] op_a [N];
   logic signed [W-1:0] op_b [N];

   int n_vec = 0;
   int n_err = 0;
   int m_last;

   always #5 clk = ~clk;

   always_comb begin
      req_dividend = '0;
      req_divisor  = '0;
      for (int i = 0; i < N; i++) begin
         req_dividend[i*W +: W] = op_a[i];
         req_divisor[i*W +: W]  = op_b[i];
      end
   end

   shared_divider_scheduler #(
      .N_REQ(N),
      .WIDTH(W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .req_stb       (req_stb),
      .req_ack       (req_ack),
      .resp_quotient (resp_quotient),
      .resp_remainder(resp_remainder),
      .resp_dbz      (resp_dbz),
      .resp_stb      (resp_stb),
      .resp_ack      (resp_ack)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // {quotient, remainder, dbz} from plain integer arithmetic.
   function automatic logic [2*W:0] ref_div(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      int qi;
      int ri;
      logic [W-1:0] q;
      logic [W-1:0] r;
      if (b == 0) return {{W{1'b1}}, a, 1'b1};
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
      q  = qi[W-1:0];
      r  = ri[W-1:0];
      return {q, r, 1'b0};
   endfunction

   function automatic int rr_pick(input logic [N-1:0] pend, input int last);
      for (int k = 1; k <= N; k++) begin
         if (pend[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic signed [W-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 16'sh8000;
         3:       return 16'sh7fff;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk(tag, 64'({req_ack, resp_stb, resp_quotient, resp_remainder, resp_dbz}), 64'(0));
   endtask

   // Serve one transaction: grant, latency, routing, data, backpressure, drop.
   task automatic serve(input int exp_gap, input int bp, input bit refill);
      int n;
      int w;
      logic [2*W:0] e;
      logic [N-1:0] onehot;
      w = rr_pick(req_stb, m_last);
      onehot = (w < 0) ? '0 : (N'(1) << w);
      n = 0;
      while (req_ack == '0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("grant", 64'(req_ack), 64'(onehot));
      if (w < 0 || req_ack != onehot) return;
      if (exp_gap >= 0) chk("grant_gap", 64'(n), 64'(exp_gap));
      m_last = w;
      e = ref_div(op_a[w], op_b[w]);
      if (refill) begin
         op_a[w] = rnd_op();
         op_b[w] = rnd_op();
      end else begin
         req_stb[w] = 1'b0;
      end
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) chk("ack_pulse", 64'(req_ack), 64'(0));
      end while (resp_stb == '0 && n < 60);
      chk("latency", 64'(n), 64'(W + 2));
      chk("resp", 64'({resp_stb, resp_quotient, resp_remainder, resp_dbz}), 64'({onehot, e}));
      resp_ack = ~onehot;
      for (int c = 0; c < bp; c++) begin
         @(posedge clk); #1;
         chk("hold", 64'({req_ack, resp_stb, resp_quotient, resp_remainder, resp_dbz}),
             64'({N'(0), onehot, e}));
      end
      resp_ack = onehot;
      @(posedge clk); #1;
      chk("resp_drop", 64'(resp_stb), 64'(0));
      resp_ack = '0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [N-1:0] seen;
      logic signed [W-1:0] sa [5];
      logic signed [W-1:0] sb [5];
      sa = '{-16'sd7, 16'sd7, 16'sh8000, 16'sd0, 16'sd100};
      sb = '{16'sd2, -16'sd2, -16'sd1, 16'sd5, 16'sd0};

      rst      = 1'b1;
      req_stb  = '0;
      resp_ack = '0;
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset_state");
      rst    = 1'b0;
      m_last = N - 1;

      op_a[0] = 16'sd7;
      op_b[0] = 16'sd2;
      req_stb[0] = 1'b1;
      serve(1, 0, 1'b0);

      for (int i = 0; i < 5; i++) begin
         op_a[1] = sa[i];
         op_b[1] = sb[i];
         req_stb[1] = 1'b1;
         serve(1, 0, 1'b0);
      end

      // Fairness from a fresh reset with every requester held high.
      rst = 1'b1;
      @(posedge clk); #1;
      rst    = 1'b0;
      m_last = N - 1;
      for (int i = 0; i < N; i++) begin
         op_a[i] = W'(1000 * (i + 1) + 7);
         op_b[i] = W'(i + 3);
      end
      req_stb = '1;
      for (int i = 0; i < 5; i++) begin
         serve(1, 0, 1'b1);
         chk("rr_order", 64'(m_last), 64'(i % N));
      end

      serve(1, 0, 1'b0);
      serve(1, 10, 1'b0);
      chk("bp_id", 64'(m_last), 64'(2));
      serve(1, 0, 1'b0);
      serve(1, 0, 1'b0);

      // Abort an operation five cycles after its grant.
      op_a[2] = 16'sd1234;
      op_b[2] = -16'sd7;
      req_stb[2] = 1'b1;
      n = 0;
      while (req_ack == '0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("abort_grant", 64'(req_ack), 64'(4'b0100));
      req_stb[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals("mid_reset");
      rst    = 1'b0;
      m_last = N - 1;
      seen   = '0;
      repeat (30) begin
         @(posedge clk); #1;
         seen |= resp_stb;
      end
      chk("no_orphan_resp", 64'(seen), 64'(0));
      op_a[0] = -16'sd300;
      op_b[0] = 16'sd9;
      op_a[3] = 16'sd55;
      op_b[3] = 16'sd4;
      req_stb[0] = 1'b1;
      req_stb[3] = 1'b1;
      serve(1, 0, 1'b0);
      chk("post_reset_prio", 64'(m_last), 64'(0));
      serve(1, 0, 1'b0);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_stb[i] && $urandom_range(0, 2) == 0) begin
               op_a[i] = rnd_op();
               op_b[i] = rnd_op();
               req_stb[i] = 1'b1;
            end
         end
         if (req_stb == '0) begin
            n = $urandom_range(0, N - 1);
            op_a[n] = rnd_op();
            op_b[n] = rnd_op();
            req_stb[n] = 1'b1;
         end
         serve(1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 2 * N && req_stb != '0; i++) serve(1, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
